// File: rtl/exu_muldiv_ysyx23060136_if.sv
// EX stage <-> RV32M multiply/divide unit signal bundle.
// The EX stage is the master; the muldiv unit is the slave.
interface exu_muldiv_ysyx23060136_if;
  logic        EXU_i_commit;
  logic        EXU_i_muldiv;
  logic [2:0]  EXU_i_funct3;
  logic [31:0] EXU_i_rs1_data;
  logic [31:0] EXU_i_rs2_data;
  logic        EXU_i_hold;
  logic        MULDIV_i_kill;
  logic        MULDIV_o_stall;
  logic        MULDIV_o_done;
  logic [31:0] MULDIV_o_result;

  modport master (
    output EXU_i_commit, EXU_i_muldiv, EXU_i_funct3, EXU_i_rs1_data,
           EXU_i_rs2_data, EXU_i_hold, MULDIV_i_kill,
    input  MULDIV_o_stall, MULDIV_o_done, MULDIV_o_result
  );

  modport slave (
    input  EXU_i_commit, EXU_i_muldiv, EXU_i_funct3, EXU_i_rs1_data,
           EXU_i_rs2_data, EXU_i_hold, MULDIV_i_kill,
    output MULDIV_o_stall, MULDIV_o_done, MULDIV_o_result
  );
endinterface

// File: rtl/exu_muldiv_ysyx23060136.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, 32 CALC cycles plus one FIX cycle that applies signs.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module exu_muldiv_ysyx23060136 (
  input  logic                          clk,
  input  logic                          rst,   // active-low, asynchronous
  exu_muldiv_ysyx23060136_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;       // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;      // mul: multiplicand magnitude; div: divisor magnitude
  logic        sign_a, sign_b;
  logic [2:0]  f3_q;
  logic [31:0] result_q;

  // Operand decode for the instruction currently presented by EX
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic        is_div_in, sa_in, sb_in, div_zero, div_ovf, fast;
  logic [31:0] a_mag_in, b_mag_in, fast_result;
  logic        start, stall;

  assign f3        = bus.EXU_i_funct3;
  assign rs1       = bus.EXU_i_rs1_data;
  assign rs2       = bus.EXU_i_rs2_data;
  assign is_div_in = f3[2];
  // a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM
  assign sa_in     = rs1[31] & ((f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110));
  assign sb_in     = rs2[31] & ((f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110));
  assign a_mag_in  = sa_in ? -rs1 : rs1;
  assign b_mag_in  = sb_in ? -rs2 : rs2;
  assign div_zero  = is_div_in & (rs2 == 32'd0);
  assign div_ovf   = is_div_in & ~f3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
  assign fast      = div_zero | div_ovf;
  // f3[1] selects REM/REMU over DIV/DIVU
  assign fast_result = div_zero ? (f3[1] ? rs1 : 32'hFFFF_FFFF)
                                : (f3[1] ? 32'd0 : 32'h8000_0000);

  // Gating with rst keeps stall low while reset is asserted
  assign start = rst & (state == S_IDLE) & bus.EXU_i_commit & bus.EXU_i_muldiv & ~bus.MULDIV_i_kill;

  // One iteration step for each operation class
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_next, div_next;
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next  = {mul_sum, acc[31:1]};
  assign div_trial = acc[63:31] - {1'b0, opnd};
  assign div_next  = div_trial[32] ? {acc[62:0], 1'b0}
                                   : {div_trial[31:0], acc[30:0], 1'b1};

  // Sign fix-up of the raw magnitude result
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_result;
  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
  assign rem_fix  = sign_a ? -acc[63:32] : acc[63:32];

  // Select the architectural result from the fixed-up product/quotient/remainder
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fix_result = rem_fix;
    case (f3_q)
      3'b000:                 fix_result = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[63:32];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    stall     = start;
    case (state)
      S_IDLE: if (start) state_nxt = fast ? S_DONE : S_CALC;
      S_CALC: begin
        stall = ~bus.MULDIV_i_kill;
        if (bus.MULDIV_i_kill)   state_nxt = S_IDLE;
        else if (cnt == 5'd31)   state_nxt = S_FIX;
      end
      S_FIX: begin
        stall     = ~bus.MULDIV_i_kill;
        state_nxt = bus.MULDIV_i_kill ? S_IDLE : S_DONE;
      end
      S_DONE: if (bus.MULDIV_i_kill || !bus.EXU_i_hold) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands on start, iterate in CALC, latch result in FIX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      f3_q     <= 3'd0;
      result_q <= 32'd0;
    end else if (start) begin
      cnt    <= 5'd0;
      sign_a <= sa_in;
      sign_b <= sb_in;
      f3_q   <= f3;
      opnd   <= is_div_in ? b_mag_in : a_mag_in;
      acc    <= {32'd0, is_div_in ? a_mag_in : b_mag_in};
      if (fast) result_q <= fast_result;
    end else if (state == S_CALC && !bus.MULDIV_i_kill) begin
      acc <= f3_q[2] ? div_next : mul_next;
      cnt <= cnt + 5'd1;
    end else if (state == S_FIX && !bus.MULDIV_i_kill) begin
      result_q <= fix_result;
    end
  end

  assign bus.MULDIV_o_stall  = stall;
  assign bus.MULDIV_o_done   = (state == S_DONE);
  assign bus.MULDIV_o_result = result_q;

endmodule
